// File: rtl/decim_ctrl_pkg.sv
// decim_ctrl_pkg: shared state encoding and default counts for the decimator sequencer
package decim_ctrl_pkg;
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    FLUSH = 2'd2
  } state_t;
  localparam int FLUSH_CE_DEF = 32;
  localparam int DISCARD_DEF  = 4;
endpackage

// File: rtl/decimator_sequencer_ce_rate_gen.sv
// ce_rate_gen: latches the divider on restart and emits a registered ce pulse every div_q clocks
module ce_rate_gen #(
  parameter int DIV_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             enable,
  input  logic             restart,
  input  logic [DIV_W-1:0] div,
  output logic             ce
);
  logic [DIV_W-1:0] div_q, div_cnt, cnt_n;
  always_comb cnt_n = (div_cnt == div_q - 1'b1) ? '0 : div_cnt + 1'b1;
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      div_q   <= '0;
      div_cnt <= '0;
      ce      <= 1'b0;
    end else if (restart) begin
      div_q   <= (div == '0) ? DIV_W'(1) : div;
      div_cnt <= '0;
      ce      <= 1'b1;
    end else if (enable) begin
      div_cnt <= cnt_n;
      ce      <= (cnt_n == '0);
    end else begin
      div_cnt <= '0;
      ce      <= 1'b0;
    end
  end
endmodule

// File: rtl/decimator_sequencer.sv
// decimator_sequencer: start/run/flush sequencing of a decimator with settling discard and a valid/ready output register
module decimator_sequencer
  import decim_ctrl_pkg::*;
#(
  parameter int DW       = 16,
  parameter int DIV_W    = 16,
  parameter int FLUSH_CE = FLUSH_CE_DEF,
  parameter int DISCARD  = DISCARD_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             stop,
  input  logic [DIV_W-1:0] div,
  output logic             ce_dec,
  input  logic             dec_ce_out,
  input  logic [DW-1:0]    dec_sig,
  output logic [DW-1:0]    m_data,
  output logic             m_valid,
  input  logic             m_ready,
  output logic             busy,
  output logic             overrun,
  input  logic             overrun_clr
);
  localparam int FW  = (FLUSH_CE > 1) ? $clog2(FLUSH_CE) : 1;
  localparam int DCW = ($clog2(DISCARD + 1) < 1) ? 1 : $clog2(DISCARD + 1);
  state_t         state, state_n;
  logic [FW-1:0]  flush_cnt;
  logic [DCW-1:0] discard_cnt;
  logic           start_acc, flush_done, discarding, keep, cap, drop;
  always_comb begin
    start_acc  = (state == IDLE) && start && !stop;
    flush_done = (state == FLUSH) && ce_dec && (flush_cnt == FW'(FLUSH_CE - 1));
    state_n    = (state == IDLE) ? (start_acc ? RUN : IDLE) :
                 (state == RUN)  ? (stop ? ((FLUSH_CE == 0) ? IDLE : FLUSH) : RUN) :
                 (flush_done ? IDLE : FLUSH);
    discarding = discard_cnt < DCW'(DISCARD);
    keep       = busy && dec_ce_out && !discarding;
    cap        = keep && (!m_valid || m_ready);
    drop       = keep && m_valid && !m_ready;
  end
  ce_rate_gen #(.DIV_W(DIV_W)) u_rate (
    .clk     (clk),
    .rst_n   (rst_n),
    .enable  (state_n != IDLE),
    .restart (start_acc),
    .div     (div),
    .ce      (ce_dec)
  );
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= IDLE;
      busy        <= 1'b0;
      flush_cnt   <= '0;
      discard_cnt <= '0;
      m_data      <= '0;
      m_valid     <= 1'b0;
      overrun     <= 1'b0;
    end else begin
      state       <= state_n;
      busy        <= (state_n != IDLE);
      flush_cnt   <= (state != FLUSH) ? '0 : ce_dec ? flush_cnt + 1'b1 : flush_cnt;
      discard_cnt <= start_acc ? '0 : (busy && dec_ce_out && discarding) ? discard_cnt + 1'b1 : discard_cnt;
      m_data      <= cap ? dec_sig : m_data;
      m_valid     <= cap ? 1'b1 : m_ready ? 1'b0 : m_valid;
      overrun     <= drop ? 1'b1 : overrun_clr ? 1'b0 : overrun;
    end
  end
endmodule

// File: doc/decimator_sequencer.md
Name: decimator_sequencer

Overview:
- Controller that drives a decimator's clock-enable input at a programmable sample rate.
- Sequences start, run and flush of the decimator; discards its settling outputs.
- Hands decimated samples downstream through a one-entry valid/ready output register with overrun detection.
- Sits between the system control registers and a decimator instance such as example_decimator (ports ce_in, ce_out, sig_out).

Parameters:
- DW, 16, sample width of the decimator output.
- DIV_W, 16, width of the ce period divider.
- FLUSH_CE, 32, ce_dec strobes issued after stop so the decimator pipeline drains.
- DISCARD, 4, decimator outputs dropped after each start (filter settling); 0 disables discarding.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  synchronous reset, active-low.
- start  in  1  single-cycle pulse; begins a run.
- stop  in  1  single-cycle pulse; ends a run via flush.
- div  in  DIV_W  ce_dec period in clocks; sampled only on an accepted start; 0 is treated as 1.
- ce_dec  out  1  clock enable to the decimator ce_in.
- dec_ce_out  in  1  decimator output-valid strobe (decimator ce_out).
- dec_sig  in  DW  decimator sig_out.
- m_data  out  DW  output sample.
- m_valid  out  1  output sample valid.
- m_ready  in  1  downstream accept.
- busy  out  1  high in RUN or FLUSH.
- overrun  out  1  sticky; a sample was lost.
- overrun_clr  in  1  clears overrun.

Behaviour:
- Reset (rst_n low at a clk edge): state IDLE; ce_dec, m_valid, busy, overrun = 0; m_data = 0; all counters = 0. Reset mid-run aborts immediately; no flush is performed.
- States:
  - IDLE: ce_dec = 0. An accepted start latches div_q = max(div,1), clears div_cnt and discard_cnt, and moves to RUN.
  - RUN: ce_dec is high on the first RUN cycle, then once every div_q clocks. div_cnt counts 0..div_q-1 and wraps; ce_dec = (div_cnt == 0). div_q = 1 gives ce_dec continuously high. stop moves to FLUSH without disturbing the cadence.
  - FLUSH: same cadence. flush_cnt counts issued strobes; after the FLUSH_CE-th strobe the next state is IDLE. If FLUSH_CE = 0, stop goes straight to IDLE.
- Command priority: start in RUN or FLUSH is ignored. stop in IDLE is ignored. start and stop together in IDLE: stop wins and the block stays IDLE.
- busy = (state != IDLE), registered with the state.
- Sample capture, evaluated on every dec_ce_out while busy:
  - While discard_cnt < DISCARD: increment discard_cnt; the sample is dropped and overrun is not affected.
  - Otherwise, if m_valid == 0 or m_ready == 1: load m_data = dec_sig and set m_valid = 1 on the next cycle. This is a simultaneous hand-off; m_valid stays 1 without a bubble.
  - Otherwise: drop the new sample (the old one is kept) and set overrun.
- dec_ce_out while IDLE is ignored.
- m_valid clears on m_valid && m_ready with no new capture. A pending sample survives the return to IDLE until it is consumed.
- Capture latency: 1 clock from dec_ce_out to m_valid/m_data.
- overrun_clr clears overrun. If an overrun event occurs in the same cycle, set wins.
- All outputs are registered; there are no combinational paths from input to output.

Decomposition:
- Shared package `decim_ctrl_pkg`:
  - state enum: IDLE = 2'd0, RUN = 2'd1, FLUSH = 2'd2.
  - default localparams for FLUSH_CE and DISCARD.
- One natural sub-module, `ce_rate_gen`: the div_q latch, div_cnt and ce pulse generation, with inputs enable and restart.
- The FSM, discard/flush counters and output register stay in the top level.

Test Plan:
1. div = 4, start, dummy decimator with ce_out every 2nd ce_in and sig = count → ce_dec on cycles 1, 5, 9, … after start; first 4 outputs discarded; 5th output appears on m_data one clock after its dec_ce_out; m_ready held 1 keeps overrun at 0.
2. div = 0 → ce_dec continuously high in RUN (identical to div = 1); stop → exactly 32 further ce_dec pulses, then busy falls and ce_dec = 0.
3. m_ready held 0 over 3 post-discard samples → m_data holds the first sample, overrun = 1; pulse overrun_clr → overrun = 0. overrun_clr coincident with a new drop → overrun stays 1.
4. m_ready = 1 in the same cycle as a new capture → m_valid stays high continuously, m_data updates, no sample lost.
5. Pulse start and stop together in IDLE → busy stays 0. start pulsed during RUN with a different div → cadence unchanged.
6. rst_n low for 1 clock during FLUSH with m_valid = 1 → the next cycle shows all outputs 0 and state IDLE; a subsequent start restarts discarding from 0.
